// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   opcode_e  - 5-bit opcode encoding
//   FLG_*     - bit positions of Z/S/C/V inside the 4-bit status word
//   state_e   - top-level FSM states
//   is_iter   - true for opcodes handled by the iterative unit
//   pack_flags- assembles a status word from individual flag bits
package alu_pkg;

  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,
    OP_NOT  = 5'd1,
    OP_AND  = 5'd2,
    OP_OR   = 5'd3,
    OP_XOR  = 5'd4,
    OP_SHL  = 5'd5,
    OP_SHR  = 5'd6,
    OP_ROL  = 5'd7,
    OP_ROR  = 5'd8,
    OP_INC  = 5'd9,
    OP_DEC  = 5'd10,
    OP_ADD  = 5'd11,
    OP_ADC  = 5'd12,
    OP_SUB  = 5'd13,
    OP_SBB  = 5'd14,
    OP_CMP  = 5'd15,
    OP_MUL  = 5'd16,
    OP_LDSR = 5'd17,
    OP_XSR  = 5'd18
  } opcode_e;

  localparam int FLG_Z = 0;
  localparam int FLG_S = 1;
  localparam int FLG_C = 2;
  localparam int FLG_V = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_iter(input logic [4:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) ||
           (op == OP_ROR) || (op == OP_MUL);
  endfunction

  function automatic logic [3:0] pack_flags(input logic v, input logic c,
                                            input logic s, input logic z);
    logic [3:0] f;
    f        = '0;
    f[FLG_V] = v;
    f[FLG_C] = c;
    f[FLG_S] = s;
    f[FLG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// alu_iter_unit: iterative datapath for shifts/rotates (one position per
// cycle) and unsigned shift-add multiply (one multiplier bit per cycle).
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (aborts any operation)
//   start        load operands and begin; only asserted with a nonzero count
//   op, mode     opcode and width mode (1 = full word, 0 = half word)
//   a, b         operands, already masked to the effective width
//   done         high during the cycle whose step is the final one
//   lo, hi       values produced by the current step (hi = 0 unless MUL)
//   cout         carry of the current step (last bit out, or hi != 0 for MUL)
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 20,
  parameter int HALF  = WIDTH / 2,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             cout
);

  // One extra bit so the counter can hold WIDTH itself.
  localparam int CW = SHW + 1;
  localparam logic [WIDTH-1:0] HALF_MASK = {{(WIDTH-HALF){1'b0}}, {HALF{1'b1}}};

  logic               busy_reg;
  logic [CW-1:0]      cnt_reg;
  logic [4:0]         op_reg;
  logic               mode_reg;
  logic [WIDTH-1:0]   sh_reg;
  logic [2*WIDTH-1:0] prod_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;

  logic [WIDTH-1:0]   mask;
  logic [WIDTH-1:0]   top_bit;
  logic               msb_out;
  logic [WIDTH-1:0]   sh_next;
  logic               sh_c;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH-1:0]   mul_lo;
  logic [WIDTH-1:0]   mul_hi;
  logic               is_mul;

  assign mask    = mode_reg ? '1 : HALF_MASK;
  assign msb_out = mode_reg ? sh_reg[WIDTH-1] : sh_reg[HALF-1];
  // Bit position that receives the LSB on a right rotate.
  assign top_bit = mode_reg ? {1'b1, {(WIDTH-1){1'b0}}}
                            : {{(WIDTH-HALF){1'b0}}, 1'b1, {(HALF-1){1'b0}}};

  always_comb begin
    sh_next = sh_reg;
    sh_c    = 1'b0;
    case (op_reg)
      OP_SHL: begin
        sh_next = (sh_reg << 1) & mask;
        sh_c    = msb_out;
      end
      OP_SHR: begin
        sh_next = sh_reg >> 1;
        sh_c    = sh_reg[0];
      end
      OP_ROL: begin
        sh_next = ((sh_reg << 1) & mask) | {{(WIDTH-1){1'b0}}, msb_out};
        sh_c    = msb_out;
      end
      OP_ROR: begin
        sh_next = (sh_reg >> 1) | (sh_reg[0] ? top_bit : '0);
        sh_c    = sh_reg[0];
      end
      default: ;
    endcase
  end

  // Operands are zero-extended, so the 2W-bit product lands in the low bits.
  assign prod_next = prod_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign mul_lo    = mode_reg ? prod_next[WIDTH-1:0]
                              : {{(WIDTH-HALF){1'b0}}, prod_next[HALF-1:0]};
  assign mul_hi    = mode_reg ? prod_next[2*WIDTH-1:WIDTH]
                              : {{(WIDTH-HALF){1'b0}}, prod_next[2*HALF-1:HALF]};

  assign is_mul = (op_reg == OP_MUL);
  assign lo     = is_mul ? mul_lo : sh_next;
  assign hi     = is_mul ? mul_hi : '0;
  assign cout   = is_mul ? (mul_hi != '0) : sh_c;
  assign done   = busy_reg && (cnt_reg == CW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_reg   <= 1'b0;
      cnt_reg    <= '0;
      op_reg     <= '0;
      mode_reg   <= 1'b0;
      sh_reg     <= '0;
      prod_reg   <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
    end else if (start) begin
      busy_reg   <= 1'b1;
      op_reg     <= op;
      mode_reg   <= mode;
      sh_reg     <= a;
      prod_reg   <= '0;
      mcand_reg  <= {{WIDTH{1'b0}}, a};
      mplier_reg <= b;
      if (op == OP_MUL) begin
        cnt_reg <= mode ? CW'(WIDTH) : CW'(HALF);
      end else begin
        cnt_reg <= {1'b0, b[SHW-1:0]};
      end
    end else if (busy_reg) begin
      sh_reg     <= sh_next;
      prod_reg   <= prod_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg - CW'(1);
      if (cnt_reg == CW'(1)) begin
        busy_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with status register and valid/ready handshakes.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   request handshake; op/mode/a/b captured on accept
//   op, mode            opcode, width mode (1 = full word, 0 = half word)
//   a, b                operands (b[SHW-1:0] is the shift count)
//   out_valid/out_ready result handshake
//   result, result_hi   result (low word) and MUL high word
//   flags               status register {V,C,S,Z}
//   illegal             undefined opcode, registered with result
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 20,
  parameter int HALF  = WIDTH / 2,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output logic             illegal
);

  localparam logic [WIDTH-1:0] HALF_MASK = {{(WIDTH-HALF){1'b0}}, {HALF{1'b1}}};

  state_e           state_reg;
  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] result_hi_reg;
  logic [3:0]       flags_reg;
  logic             illegal_reg;
  logic             mode_reg;
  logic             mul_reg;

  logic             accept;
  logic             start_iter;
  logic             shift_zero;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] a_m;
  logic [WIDTH-1:0] b_m;

  logic             one_op;
  logic [WIDTH-1:0] y;
  logic             carry_in;
  logic             borrow_in;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] sum_res;
  logic [WIDTH-1:0] diff_res;
  logic             sum_c;
  logic             diff_c;
  logic             sum_v;
  logic             diff_v;
  logic [WIDTH-1:0] logic_res;

  logic [WIDTH-1:0] sc_res;
  logic [3:0]       sc_flags;
  logic             sc_ill;

  logic             iter_done;
  logic [WIDTH-1:0] iter_lo;
  logic [WIDTH-1:0] iter_hi;
  logic             iter_c;
  logic             iter_z;
  logic [3:0]       iter_flags;

  // Sign bit of x at the effective width.
  function automatic logic msb_of(input logic [WIDTH-1:0] x, input logic md);
    return md ? x[WIDTH-1] : x[HALF-1];
  endfunction

  assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
  assign out_valid = (state_reg == DONE);
  assign accept    = in_valid && in_ready;

  assign mask = mode ? '1 : HALF_MASK;
  assign a_m  = a & mask;
  assign b_m  = b & mask;

  // A zero-count shift completes like a single-cycle op.
  assign shift_zero = (op != OP_MUL) && (b_m[SHW-1:0] == '0);
  assign start_iter = accept && is_iter(op) && !shift_zero;

  // Shared adder/subtractor; INC/DEC reuse it with a constant 1 operand.
  assign one_op    = (op == OP_INC) || (op == OP_DEC);
  assign y         = one_op ? {{(WIDTH-1){1'b0}}, 1'b1} : b_m;
  assign carry_in  = (op == OP_ADC) ? flags_reg[FLG_C] : 1'b0;
  assign borrow_in = (op == OP_SBB) ? flags_reg[FLG_C] : 1'b0;
  assign sum       = {1'b0, a_m} + {1'b0, y} + {{WIDTH{1'b0}}, carry_in};
  assign diff      = {1'b0, a_m} - {1'b0, y} - {{WIDTH{1'b0}}, borrow_in};
  assign sum_res   = sum[WIDTH-1:0] & mask;
  assign diff_res  = diff[WIDTH-1:0] & mask;
  // Operands are zero above the effective width, so bit HALF of the raw
  // sum/difference is the half-word carry/borrow.
  assign sum_c     = mode ? sum[WIDTH] : sum[HALF];
  assign diff_c    = mode ? diff[WIDTH] : diff[HALF];
  assign sum_v     = (msb_of(a_m, mode) == msb_of(y, mode)) &&
                     (msb_of(sum_res, mode) != msb_of(a_m, mode));
  assign diff_v    = (msb_of(a_m, mode) != msb_of(y, mode)) &&
                     (msb_of(diff_res, mode) != msb_of(a_m, mode));

  always_comb begin
    logic_res = '0;
    case (op)
      OP_NOT:  logic_res = ~a_m & mask;
      OP_AND:  logic_res = a_m & b_m;
      OP_OR:   logic_res = a_m | b_m;
      OP_XOR:  logic_res = a_m ^ b_m;
      default: ;
    endcase
  end

  always_comb begin
    sc_res   = '0;
    sc_flags = flags_reg;
    sc_ill   = 1'b0;
    case (op)
      OP_NOP: ;
      OP_NOT, OP_AND, OP_OR, OP_XOR: begin
        sc_res   = logic_res;
        sc_flags = pack_flags(1'b0, 1'b0, msb_of(logic_res, mode), logic_res == '0);
      end
      OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
        // Only reached with a zero count: value passes through, C kept.
        sc_res   = a_m;
        sc_flags = pack_flags(1'b0, flags_reg[FLG_C], msb_of(a_m, mode), a_m == '0);
      end
      OP_INC, OP_ADD, OP_ADC: begin
        sc_res   = sum_res;
        sc_flags = pack_flags(sum_v, sum_c, msb_of(sum_res, mode), sum_res == '0);
      end
      OP_DEC, OP_SUB, OP_SBB: begin
        sc_res   = diff_res;
        sc_flags = pack_flags(diff_v, diff_c, msb_of(diff_res, mode), diff_res == '0);
      end
      OP_CMP: begin
        sc_res   = a_m;
        sc_flags = pack_flags(diff_v, diff_c, msb_of(diff_res, mode), diff_res == '0);
      end
      OP_MUL: ;
      OP_LDSR: begin
        sc_res   = a_m;
        sc_flags = a[3:0];
      end
      OP_XSR: begin
        sc_res   = a_m;
        sc_flags = flags_reg ^ a[3:0];
      end
      default: sc_ill = 1'b1;
    endcase
  end

  alu_iter_unit #(
    .WIDTH (WIDTH),
    .HALF  (HALF),
    .SHW   (SHW)
  ) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_iter),
    .op    (op),
    .mode  (mode),
    .a     (a_m),
    .b     (b_m),
    .done  (iter_done),
    .lo    (iter_lo),
    .hi    (iter_hi),
    .cout  (iter_c)
  );

  // MUL zero test covers the full 2W-bit product; V mirrors C for MUL.
  assign iter_z     = mul_reg ? ((iter_lo | iter_hi) == '0) : (iter_lo == '0);
  assign iter_flags = pack_flags(mul_reg ? iter_c : 1'b0, iter_c,
                                 msb_of(iter_lo, mode_reg), iter_z);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      result_reg    <= '0;
      result_hi_reg <= '0;
      flags_reg     <= '0;
      illegal_reg   <= 1'b0;
      mode_reg      <= 1'b0;
      mul_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            mode_reg <= mode;
            mul_reg  <= (op == OP_MUL);
            if (start_iter) begin
              state_reg <= BUSY;
            end else begin
              state_reg     <= DONE;
              result_reg    <= sc_res;
              result_hi_reg <= '0;
              flags_reg     <= sc_flags;
              illegal_reg   <= sc_ill;
            end
          end else if ((state_reg == DONE) && out_ready) begin
            state_reg <= IDLE;
          end
        end
        BUSY: begin
          if (iter_done) begin
            state_reg     <= DONE;
            result_reg    <= iter_lo;
            result_hi_reg <= iter_hi;
            flags_reg     <= iter_flags;
            illegal_reg   <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign result    = result_reg;
  assign result_hi = result_hi_reg;
  assign flags     = flags_reg;
  assign illegal   = illegal_reg;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH=20). Each accepted request
// pushes its expected result/flags/latency; the monitor pops and compares
// when the DUT hands a result over.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int WIDTH = 20;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [4:0]       op = '0;
  logic             mode = 1'b1;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic [3:0]       flags;
  logic             illegal;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] hi;
    logic [3:0]       fl;
    logic             ill;
    int               acc;
    int               lat;
  } exp_t;

  exp_t sb[$];

  alu_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .flags     (flags),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input string name, input logic [4:0] o, input logic md,
                      input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                      input logic [WIDTH-1:0] er, input logic [WIDTH-1:0] eh,
                      input logic [3:0] ef, input logic ei, input int lat,
                      input bit push);
    exp_t e;
    int   n;
    @(negedge clk);
    op = o; mode = md; a = av; b = bv; in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      check({name, "_ready_timeout"}, in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    e.name = name; e.res = er; e.hi = eh; e.fl = ef; e.ill = ei;
    e.acc = cyc; e.lat = lat;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: latency on the first cycle a result is visible, contents on handover.
  initial begin
    bit fresh_seen;
    fresh_seen = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", out_valid, 0);
        end else begin
          if (!fresh_seen) begin
            check({sb[0].name, "_latency"}, cyc - sb[0].acc, sb[0].lat);
            fresh_seen = 1'b1;
          end
          if (out_ready) begin
            $display("txn %s: result=%05h hi=%05h flags=%h illegal=%b",
                     sb[0].name, result, result_hi, flags, illegal);
            check({sb[0].name, "_result"}, result, sb[0].res);
            check({sb[0].name, "_result_hi"}, result_hi, sb[0].hi);
            check({sb[0].name, "_flags"}, flags, sb[0].fl);
            check({sb[0].name, "_illegal"}, illegal, sb[0].ill);
            void'(sb.pop_front());
            fresh_seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_result_hi", result_hi, 0);
    check("rst_flags", flags, 0);
    check("rst_illegal", illegal, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #3;
    check("rst_in_ready", in_ready, 1);

    //   name          op      md    a          b          result     hi         flg   ill lat push
    send("ADD_full",   OP_ADD, 1'b1, 20'hFFFFF, 20'h00001, 20'h00000, 20'h00000, 4'h5, 0, 1,  1);
    send("ADD_half",   OP_ADD, 1'b0, 20'hAB3FF, 20'h00001, 20'h00000, 20'h00000, 4'h5, 0, 1,  1);
    send("ADC",        OP_ADC, 1'b1, 20'h00000, 20'h00000, 20'h00001, 20'h00000, 4'h0, 0, 1,  1);
    send("MUL_full",   OP_MUL, 1'b1, 20'h00400, 20'h00400, 20'h00000, 20'h00001, 4'hC, 0, 21, 1);
    send("SHL3",       OP_SHL, 1'b1, 20'h80001, 20'h00003, 20'h00008, 20'h00000, 4'h0, 0, 4,  1);
    send("ROR1",       OP_ROR, 1'b1, 20'h00001, 20'h00001, 20'h80000, 20'h00000, 4'h6, 0, 2,  1);
    send("AND",        OP_AND, 1'b1, 20'hF0F0F, 20'h0FF00, 20'h00F00, 20'h00000, 4'h0, 0, 1,  1);
    send("OR_half",    OP_OR,  1'b0, 20'h12300, 20'h000FF, 20'h003FF, 20'h00000, 4'h2, 0, 1,  1);
    send("XOR",        OP_XOR, 1'b1, 20'h5A5A5, 20'h5A5A5, 20'h00000, 20'h00000, 4'h1, 0, 1,  1);
    send("NOT_half",   OP_NOT, 1'b0, 20'h00000, 20'h00000, 20'h003FF, 20'h00000, 4'h2, 0, 1,  1);
    send("INC",        OP_INC, 1'b1, 20'h7FFFF, 20'h00000, 20'h80000, 20'h00000, 4'hA, 0, 1,  1);
    send("DEC",        OP_DEC, 1'b1, 20'h00000, 20'h00000, 20'hFFFFF, 20'h00000, 4'h6, 0, 1,  1);
    send("CMP",        OP_CMP, 1'b1, 20'h00005, 20'h00007, 20'h00005, 20'h00000, 4'h6, 0, 1,  1);
    send("SHR2",       OP_SHR, 1'b1, 20'h00003, 20'h00002, 20'h00000, 20'h00000, 4'h5, 0, 3,  1);
    send("ROL_half",   OP_ROL, 1'b0, 20'h00200, 20'h00001, 20'h00001, 20'h00000, 4'h4, 0, 2,  1);
    send("SHL0",       OP_SHL, 1'b1, 20'h12345, 20'h00000, 20'h12345, 20'h00000, 4'h4, 0, 1,  1);
    send("SHL_big",    OP_SHL, 1'b0, 20'h003FF, 20'h00014, 20'h00000, 20'h00000, 4'h1, 0, 21, 1);
    send("MUL_half",   OP_MUL, 1'b0, 20'h003FF, 20'h003FF, 20'h00001, 20'h003FE, 4'hC, 0, 11, 1);
    drain();

    // Backpressure: SUB result must hold while a pending SBB waits.
    out_ready = 1'b0;
    send("SUB",        OP_SUB, 1'b1, 20'h00000, 20'h00001, 20'hFFFFF, 20'h00000, 4'h6, 0, 1,  1);
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          #3;
          check("bp_result", result, 20'hFFFFF);
          check("bp_flags", flags, 4'h6);
          check("bp_out_valid", out_valid, 1);
          check("bp_in_ready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        #3;
        check("b2b_sbb_out_valid", out_valid, 1);
        check("b2b_sbb_result", result, 20'h00002);
      end
      send("SBB",      OP_SBB, 1'b1, 20'h00005, 20'h00002, 20'h00002, 20'h00000, 4'h0, 0, 1,  1);
    join
    send("XSR",        OP_XSR, 1'b1, 20'h0000F, 20'h00000, 20'h0000F, 20'h00000, 4'hF, 0, 1,  1);
    drain();

    // Reset in the middle of a MUL: aborted, nothing produced.
    send("MUL_abort",  OP_MUL, 1'b1, 20'h00003, 20'h00005, 20'h00000, 20'h00000, 4'h0, 0, 21, 0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #3;
    check("abort_out_valid", out_valid, 0);
    check("abort_flags", flags, 0);
    check("abort_in_ready", in_ready, 1);
    rst_n = 1'b1;

    send("LDSR",       OP_LDSR, 1'b1, 20'h1234A, 20'h00000, 20'h1234A, 20'h00000, 4'hA, 0, 1, 1);
    send("ILL25",      5'd25,   1'b1, 20'h12345, 20'h06789, 20'h00000, 20'h00000, 4'hA, 1, 1, 1);
    send("NOP",        OP_NOP,  1'b1, 20'h11111, 20'h22222, 20'h00000, 20'h00000, 4'hA, 0, 1, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
